// File: rtl/mmio_console_fifo.sv
// Memory-mapped console device on the core store path.
// Channel stores are tagged with their channel and print mode and queued in a
// small FIFO that drains to a valid/ready sink. Also holds the per-channel
// mode register, the exit/pass-fail mailbox and a readable status word.
module mmio_console_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FFE0,
  parameter int          NUM_CHAN  = 4,
  parameter int          DEPTH     = 8,
  parameter int          OVF_W     = 16
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             memwrite,
  input  logic [31:0]                                      dataadr,
  input  logic [31:0]                                      writedata,
  output logic                                             rd_hit,
  output logic [31:0]                                      readdata,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [31:0]                                      out_data,
  output logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] out_chan,
  output logic                                             out_char,
  output logic                                             done,
  output logic                                             pass,
  output logic [31:0]                                      exit_code,
  output logic                                             finished,
  output logic [OVF_W-1:0]                                 ovf_count
);

  localparam int CW   = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  typedef struct packed {
    logic [31:0]   data;
    logic [CW-1:0] chan;
    logic          is_char;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [NUM_CHAN-1:0] mode_q, mode_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [31:0]         exit_code_q, exit_code_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;

  logic [31:0] addr_off;
  logic [29:0] word_idx;
  logic        aligned;
  logic        ch_hit, mode_hit, exit_hit, status_hit;
  logic        push_req, push, pop, full, empty;
  entry_t      new_entry;
  entry_t      head;

  // Register decode: offset from the base must be an exact word index; addresses below the base wrap far out of range
  always_comb begin
    addr_off   = dataadr - BASE_ADDR;
    word_idx   = addr_off[31:2];
    aligned    = (addr_off[1:0] == 2'b00);
    ch_hit     = aligned && (word_idx < 30'(NUM_CHAN));
    mode_hit   = aligned && (word_idx == 30'(NUM_CHAN));
    exit_hit   = aligned && (word_idx == 30'(NUM_CHAN + 1));
    status_hit = aligned && (word_idx == 30'(NUM_CHAN + 2));
  end

  // FIFO control, mode/exit register updates and the saturating drop counter
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNTW'(DEPTH));
    out_valid = !empty;
    pop       = out_valid && out_ready;
    push_req  = memwrite && ch_hit && !done_q;
    push      = push_req && (!full || pop);

    new_entry.chan    = word_idx[CW-1:0];
    new_entry.is_char = mode_q[word_idx[CW-1:0]];
    new_entry.data    = new_entry.is_char ? {24'h0, writedata[7:0]} : writedata;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CNTW'(push) - CNTW'(pop);

    ovf_d = ovf_q;
    if (push_req && full && !pop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end

    mode_d = mode_q;
    if (memwrite && mode_hit) begin
      mode_d = writedata[NUM_CHAN-1:0];
    end

    done_d      = done_q;
    pass_d      = pass_q;
    exit_code_d = exit_code_q;
    if (memwrite && exit_hit && !done_q) begin
      done_d      = 1'b1;
      pass_d      = (writedata == 32'h0);
      exit_code_d = writedata;
    end
  end

  // State registers; reset discards queued entries immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exit_code_q <= '0;
      ovf_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      exit_code_q <= exit_code_d;
      ovf_q       <= ovf_d;
    end
  end

  // Head read straight from storage and forced to zero while the queue is empty; readback mux for MODE/STATUS
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_data  = out_valid ? head.data : 32'h0;
    out_chan  = out_valid ? head.chan : '0;
    out_char  = out_valid ? head.is_char : 1'b0;
    done      = done_q;
    pass      = pass_q;
    exit_code = exit_code_q;
    finished  = done_q && empty;
    ovf_count = ovf_q;
    rd_hit    = mode_hit || status_hit;
    readdata  = 32'h0;
    if (mode_hit) begin
      readdata = 32'(mode_q);
    end else if (status_hit) begin
      readdata = {16'(ovf_q), 8'(count_q), 6'b0, full, empty};
    end
  end

endmodule

// File: tb/tb_mmio_console_fifo.sv
// Self-checking bench for mmio_console_fifo: a queue-based model of the console
// is checked against the DUT every cycle, with directed scenarios pinning the
// model to hand-computed values and a randomized phase exercising the rest.
module tb_mmio_console_fifo;

  localparam logic [31:0] BASE     = 32'h0000_FFE0;
  localparam int          NUM_CHAN = 4;
  localparam int          DEPTH    = 8;
  localparam int          OVF_W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              memwrite;
  logic [31:0]       dataadr;
  logic [31:0]       writedata;
  logic              rd_hit;
  logic [31:0]       readdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [1:0]        out_chan;
  logic              out_char;
  logic              done;
  logic              pass;
  logic [31:0]       exit_code;
  logic              finished;
  logic [OVF_W-1:0]  ovf_count;

  mmio_console_fifo #(
    .BASE_ADDR(BASE),
    .NUM_CHAN (NUM_CHAN),
    .DEPTH    (DEPTH),
    .OVF_W    (OVF_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .dataadr  (dataadr),
    .writedata(writedata),
    .rd_hit   (rd_hit),
    .readdata (readdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_char (out_char),
    .done     (done),
    .pass     (pass),
    .exit_code(exit_code),
    .finished (finished),
    .ovf_count(ovf_count)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          chan;
    bit          is_char;
  } item_t;

  item_t       mq[$];
  logic [3:0]  m_mode;
  bit          m_done;
  bit          m_pass;
  logic [31:0] m_code;
  int          m_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_mode = '0;
    m_done = 0;
    m_pass = 0;
    m_code = '0;
    m_ovf  = 0;
  endtask

  // Register index k for an address, or -1 if nothing in the map is selected
  function automatic int decode(input logic [31:0] a);
    longint off;
    if (a < BASE) return -1;
    off = longint'(a) - longint'(BASE);
    if (off % 4 != 0) return -1;
    if (off / 4 >= NUM_CHAN + 3) return -1;
    return int'(off / 4);
  endfunction

  function automatic logic [31:0] modelStatus();
    int sz;
    sz = mq.size();
    return 32'((m_ovf << 16) + (sz << 8) + ((sz == DEPTH) ? 2 : 0) + ((sz == 0) ? 1 : 0));
  endfunction

  // Compare every DUT output against what the model says for the current state and inputs
  task automatic checkOutput();
    int          k;
    logic [31:0] exp_rd;
    k = decode(dataadr);
    exp_rd = (k == NUM_CHAN) ? 32'(m_mode) : (k == NUM_CHAN + 2) ? modelStatus() : 32'h0;
    checkVal("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    checkVal("out_data",  out_data,       (mq.size() > 0) ? mq[0].data : 32'h0);
    checkVal("out_chan",  32'(out_chan),  (mq.size() > 0) ? 32'(mq[0].chan) : 32'h0);
    checkVal("out_char",  32'(out_char),  (mq.size() > 0) ? 32'(mq[0].is_char) : 32'h0);
    checkVal("done",      32'(done),      32'(m_done));
    checkVal("pass",      32'(pass),      32'(m_pass));
    checkVal("exit_code", exit_code,      m_code);
    checkVal("finished",  32'(finished),  32'(m_done && mq.size() == 0));
    checkVal("ovf_count", 32'(ovf_count), 32'(m_ovf));
    checkVal("rd_hit",    32'(rd_hit),    32'(k == NUM_CHAN || k == NUM_CHAN + 2));
    checkVal("readdata",  readdata,       exp_rd);
  endtask

  // Advance the model by one rising edge using the inputs held across it
  task automatic modelEdge();
    int    k;
    int    sz;
    bit    pop;
    item_t it;
    k   = decode(dataadr);
    sz  = mq.size();
    pop = (sz > 0) && out_ready;
    if (pop) void'(mq.pop_front());
    if (memwrite && k >= 0 && k < NUM_CHAN && !m_done) begin
      if (sz < DEPTH || pop) begin
        it.is_char = m_mode[k];
        it.data    = it.is_char ? (writedata & 32'hFF) : writedata;
        it.chan    = k;
        mq.push_back(it);
      end else if (m_ovf < (1 << OVF_W) - 1) begin
        m_ovf++;
      end
    end
    if (memwrite && k == NUM_CHAN) m_mode = writedata[3:0];
    if (memwrite && k == NUM_CHAN + 1 && !m_done) begin
      m_done = 1;
      m_code = writedata;
      m_pass = (writedata == 32'h0);
    end
  endtask

  // One clock: check outputs mid-cycle, then cross the edge and update the model
  task automatic applyStimulus();
    #2;
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    applyStimulus();
    memwrite  = 1'b0;
  endtask

  task automatic idle();
    memwrite = 1'b0;
    applyStimulus();
  endtask

  task automatic peek(input logic [31:0] a);
    dataadr = a;
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic applyReset();
    memwrite = 1'b0;
    #2;
    reset = 1'b1;
    modelReset();
    #2;
    reset = 1'b0;
  endtask

  int unsigned exp4[8] = '{101, 102, 103, 104, 105, 106, 107, 200};

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          pick;
    int          ready_bias;
    logic [31:0] a;

    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'h0;
    writedata = 32'h0;
    out_ready = 1'b0;
    modelReset();
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    checkVal("rst_valid", 32'(out_valid), 32'h0);
    peek(BASE + 24);
    checkVal("rst_status", readdata, 32'h0000_0001);

    // Word store to CH0 appears next cycle and is popped one cycle later
    out_ready = 1'b1;
    store(BASE, 32'd42);
    checkVal("s1_valid", 32'(out_valid), 32'h1);
    checkVal("s1_data", out_data, 32'd42);
    checkVal("s1_chan", 32'(out_chan), 32'h0);
    checkVal("s1_char", 32'(out_char), 32'h0);
    idle();
    checkVal("s1_popped", 32'(out_valid), 32'h0);

    // Char mode truncates to a byte and tags the channel
    out_ready = 1'b0;
    store(BASE + 16, 32'h3);
    store(BASE + 4, 32'h141);
    checkVal("s2_data", out_data, 32'h41);
    checkVal("s2_char", 32'(out_char), 32'h1);
    checkVal("s2_chan", 32'(out_chan), 32'h1);
    peek(BASE + 16);
    checkVal("s2_rdhit", 32'(rd_hit), 32'h1);
    checkVal("s2_mode", readdata, 32'h3);
    out_ready = 1'b1;
    idle();
    store(BASE + 16, 32'h0);

    // Overflow: 10 stores into an 8-deep queue, then ordered drain
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) store(BASE, 32'(i));
    peek(BASE + 24);
    checkVal("s3_status_full", readdata, 32'h0002_0802);
    checkVal("s3_ovf", 32'(ovf_count), 32'd2);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checkVal("s3_drain", out_data, 32'(i));
      idle();
    end
    checkVal("s3_empty", 32'(out_valid), 32'h0);
    peek(BASE + 24);
    checkVal("s3_status_empty", readdata, 32'h0002_0001);

    // Full queue with simultaneous push and pop keeps count and order
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(BASE, 32'(100 + i));
    out_ready = 1'b1;
    store(BASE, 32'd200);
    peek(BASE + 24);
    checkVal("s4_status", readdata, 32'h0002_0802);
    for (int i = 0; i < 8; i++) begin
      checkVal("s4_order", out_data, exp4[i]);
      idle();
    end

    // Exit mailbox: first write wins, channel stores ignored afterwards
    out_ready = 1'b0;
    store(BASE, 32'd7);
    store(BASE, 32'd8);
    store(BASE, 32'd9);
    store(BASE + 20, 32'h0);
    checkVal("s5_done", 32'(done), 32'h1);
    checkVal("s5_pass", 32'(pass), 32'h1);
    checkVal("s5_finished", 32'(finished), 32'h0);
    store(BASE, 32'd999);
    peek(BASE + 24);
    checkVal("s5_status", readdata, 32'h0002_0300);
    store(BASE + 20, 32'd5);
    checkVal("s5_code", exit_code, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    checkVal("s5_finished_end", 32'(finished), 32'h1);

    // Asynchronous reset in the middle of a cycle with a loaded queue
    applyReset();
    out_ready = 1'b0;
    store(BASE + 16, 32'h5);
    for (int i = 0; i < 10; i++) store(BASE + 8, 32'(i * 37 + 300));
    store(BASE + 20, 32'd7);
    checkVal("s6_valid_pre", 32'(out_valid), 32'h1);
    checkVal("s6_pass_pre", 32'(pass), 32'h0);
    dataadr = BASE + 16;
    #2;
    reset = 1'b1;
    #1;
    checkVal("s6_valid", 32'(out_valid), 32'h0);
    checkVal("s6_done", 32'(done), 32'h0);
    checkVal("s6_ovf", 32'(ovf_count), 32'h0);
    checkVal("s6_mode", readdata, 32'h0);
    modelReset();
    #2;
    reset = 1'b0;

    // Randomized traffic against the model
    ready_bias = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 499) applyReset();
      if (cyc % 100 == 0) ready_bias = $urandom_range(0, 4);
      pick = $urandom_range(0, 15);
      case (pick)
        0, 1, 2, 3, 4, 5, 6: a = BASE + 32'(4 * $urandom_range(0, NUM_CHAN - 1));
        7:                   a = BASE + 16;
        8:                   a = BASE + 24;
        9:                   a = ($urandom_range(0, 399) == 0) ? BASE + 20 : BASE;
        10:                  a = BASE + 32'($urandom_range(1, 3));
        11:                  a = BASE - 4;
        12:                  a = BASE + 28;
        13:                  a = BASE + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(1, 3));
        default:             a = $urandom;
      endcase
      dataadr   = a;
      writedata = (pick == 7) ? 32'($urandom_range(0, 15)) : $urandom;
      memwrite  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) < ready_bias);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
